// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and memory-wait controller for the 5-stage RISC-V pipeline: EX forwarding,
// load-use / branch stall and flush control, a data-memory wait/timeout FSM and perf counters.
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic [4:0]       RdM,
  input  logic             RegWriteM,
  input  logic             MemAccessM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteW,
  input  logic             mem_ready,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             mem_req,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             dbg_state
);

  // Memory handshake: mem_req is held high from the request cycle until the
  // cycle mem_ready is seen (or the timeout release cycle); mem_ready is only
  // meaningful while mem_req is high, and completes the access in that cycle.

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam int WCW = $clog2(TIMEOUT);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

  state_t         state, state_n;
  logic [WCW-1:0] wait_cnt, wait_cnt_n;
  logic           mem_stall;
  logic           mem_req_raw;
  logic           err_set;
  logic           lw_stall;

  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
      if (err_set) mem_err <= 1'b1;
    end
  end

  always_comb begin
    state_n     = state;
    wait_cnt_n  = wait_cnt;
    mem_stall   = 1'b0;
    mem_req_raw = 1'b0;
    err_set     = 1'b0;
    case (state)
      IDLE: begin
        mem_req_raw = MemAccessM;
        if (MemAccessM && !mem_ready) begin
          mem_stall  = 1'b1;
          state_n    = WAIT;
          wait_cnt_n = '0;
        end
      end
      WAIT: begin
        mem_req_raw = 1'b1;
        if (mem_ready) begin
          state_n = IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          err_set = 1'b1;
          state_n = IDLE;
        end else begin
          mem_stall  = 1'b1;
          wait_cnt_n = wait_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // The request is withdrawn the moment reset rises, even mid-access.
  assign mem_req = mem_req_raw & ~rst;

  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))      ForwardAE = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) ForwardAE = 2'b01;
  end

  always_comb begin
    ForwardBE = 2'b00;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))      ForwardBE = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) ForwardBE = 2'b01;
  end

  assign lw_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));

  // A memory stall freezes F..M, so load-use and branch effects wait for release.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = lw_stall;
      StallD = lw_stall;
      FlushD = PCSrcE;
      FlushE = lw_stall | PCSrcE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((mem_stall || lw_stall) && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
      if (FlushD && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus randomized
// traffic against a behavioural model; a 4-bit-counter instance checks saturation.
module tb_pipeline_hazard_ctrl;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0, RdM = '0, RdW = '0;
  logic [1:0] ResultSrcE = '0;
  logic PCSrcE = 0, RegWriteM = 0, MemAccessM = 0, RegWriteW = 0, mem_ready = 0;

  logic [1:0] fa, fb, fa4, fb4;
  logic sf, sd, se, sm, fd, fe, fw, mreq, merr, dbg;
  logic sf4, sd4, se4, sm4, fd4, fe4, fw4, mreq4, merr4, dbg4;
  logic [15:0] scnt_o, fcnt_o;
  logic [3:0]  scnt4_o, fcnt4_o;

  pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RdM(RdM), .RegWriteM(RegWriteM),
    .MemAccessM(MemAccessM), .RdW(RdW), .RegWriteW(RegWriteW), .mem_ready(mem_ready),
    .ForwardAE(fa), .ForwardBE(fb), .StallF(sf), .StallD(sd), .StallE(se), .StallM(sm),
    .FlushD(fd), .FlushE(fe), .FlushW(fw), .mem_req(mreq), .mem_err(merr),
    .stall_cnt(scnt_o), .flush_cnt(fcnt_o), .dbg_state(dbg));

  pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RdM(RdM), .RegWriteM(RegWriteM),
    .MemAccessM(MemAccessM), .RdW(RdW), .RegWriteW(RegWriteW), .mem_ready(mem_ready),
    .ForwardAE(fa4), .ForwardBE(fb4), .StallF(sf4), .StallD(sd4), .StallE(se4), .StallM(sm4),
    .FlushD(fd4), .FlushE(fe4), .FlushW(fw4), .mem_req(mreq4), .mem_err(merr4),
    .stall_cnt(scnt4_o), .flush_cnt(fcnt4_o), .dbg_state(dbg4));

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  int total = 0;
  int bad = 0;
  logic [11:0] exp_q[$];

  // Model: an access is "outstanding" after its first stall cycle; it ends on
  // mem_ready or once it has already delivered TIMEOUT stall cycles.
  bit m_busy = 0;
  int m_stalled = 0;
  bit m_err = 0;
  int m_scnt = 0;
  int m_fcnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  bit cur_ms;
  bit cur_lw;

  // Sample at the falling edge: compare everything against the model.
  task automatic sample();
    logic [11:0] e;
    logic [11:0] got;
    logic [11:0] got4;
    @(negedge clk);
    cur_lw = (ResultSrcE == 2'b01) && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    if (!m_busy) cur_ms = MemAccessM && !mem_ready;
    else         cur_ms = !mem_ready && (m_stalled < TIMEOUT);
    e[11:10] = fwd(Rs1E);
    e[9:8]   = fwd(Rs2E);
    e[7] = cur_ms | cur_lw;
    e[6] = cur_ms | cur_lw;
    e[5] = cur_ms;
    e[4] = cur_ms;
    e[3] = !cur_ms && PCSrcE;
    e[2] = !cur_ms && (cur_lw || PCSrcE);
    e[1] = cur_ms;
    e[0] = m_busy ? 1'b1 : MemAccessM;
    exp_q.push_back(e);
    got  = {fa, fb, sf, sd, se, sm, fd, fe, fw, mreq};
    got4 = {fa4, fb4, sf4, sd4, se4, sm4, fd4, fe4, fw4, mreq4};
    e = exp_q.pop_front();
    check("ctl", 32'(got), 32'(e));
    check("ctl4", 32'(got4), 32'(e));
    check("mem_err", 32'(merr), 32'(m_err));
    check("stall_cnt", 32'(scnt_o), 32'(sat(m_scnt, 65535)));
    check("flush_cnt", 32'(fcnt_o), 32'(sat(m_fcnt, 65535)));
    check("stall_cnt4", 32'(scnt4_o), 32'(sat(m_scnt, 15)));
    check("flush_cnt4", 32'(fcnt4_o), 32'(sat(m_fcnt, 15)));
  endtask

  // Apply the rising edge to the model, then to the DUT.
  task automatic advance();
    if (cur_ms || cur_lw) m_scnt++;
    if (!cur_ms && PCSrcE) m_fcnt++;
    if (!m_busy) begin
      if (cur_ms) begin m_busy = 1; m_stalled = 1; end
    end else if (mem_ready) begin
      m_busy = 0;
    end else if (m_stalled == TIMEOUT) begin
      m_busy = 0;
      m_err = 1;
    end else begin
      m_stalled++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    ResultSrcE = 2'b00;
    {PCSrcE, RegWriteM, MemAccessM, RegWriteW, mem_ready} = '0;
  endtask

  // Asynchronous reset raised between edges; inputs left as they were.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    check("rst_mem_req", 32'({mreq, mreq4}), 32'd0);
    check("rst_mem_err", 32'({merr, merr4}), 32'd0);
    check("rst_cnt", 32'({scnt_o, fcnt_o, scnt4_o}), 32'd0);
    check("rst_state", 32'(dbg), 32'd0);
    clear_inputs();
    m_busy = 0; m_stalled = 0; m_err = 0; m_scnt = 0; m_fcnt = 0;
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_inputs();
    #3;
    check("reset_outputs", 32'({fa, fb, sf, sd, se, sm, fd, fe, fw, mreq, merr}), 32'd0);
    check("reset_cnts", 32'({scnt_o, fcnt_o}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Forwarding priority and x0 handling
    RdM = 5; RdW = 5; Rs1E = 5; RegWriteM = 1; RegWriteW = 1;
    sample(); check("fwdA_m_prio", 32'(fa), 32'd2); advance();
    RdM = 0; RdW = 3; Rs2E = 3; Rs1E = 0;
    sample(); check("fwdB_w", 32'(fb), 32'd1); advance();
    RdW = 0; Rs2E = 0;
    sample(); check("fwd_x0", 32'({fa, fb}), 32'd0); advance();
    clear_inputs();

    // Load-use
    do_reset();
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
    sample(); check("lw_stall", 32'({sf, sd, fe}), 32'b111); advance();
    clear_inputs();
    sample(); check("lw_cnt", 32'(scnt_o), 32'd1); advance();

    // Branch flush
    do_reset();
    PCSrcE = 1;
    sample(); check("br_flush", 32'({fd, fe}), 32'b11); advance();
    clear_inputs();
    sample(); check("br_cnt", 32'(fcnt_o), 32'd1); advance();

    // Memory access ready three cycles after request
    do_reset();
    MemAccessM = 1;
    for (int i = 0; i < 3; i++) begin
      sample(); check("mw_stall", 32'({sf, sd, se, sm, fw}), 32'h1f); advance();
    end
    mem_ready = 1;
    sample(); check("mw_release", 32'({sm, mreq}), 32'b01); advance();
    clear_inputs();
    sample(); check("mw_idle", 32'(dbg), 32'd0); check("mw_cnt", 32'(scnt_o), 32'd3); advance();

    // Timeout, then reset mid-WAIT of a second access
    do_reset();
    MemAccessM = 1;
    for (int i = 0; i < TIMEOUT; i++) begin
      sample(); check("to_stall", 32'(sm), 32'd1); advance();
    end
    sample(); check("to_release", 32'({sm, mreq, merr}), 32'b010); advance();
    MemAccessM = 0;
    sample(); check("to_err", 32'(merr), 32'd1); check("to_cnt", 32'(scnt_o), 32'(TIMEOUT)); advance();
    MemAccessM = 1;
    cycle(); cycle();
    do_reset();
    cycle();

    // Branch during memory stall is deferred
    MemAccessM = 1; PCSrcE = 1;
    for (int i = 0; i < 2; i++) begin
      sample(); check("defer_noflush", 32'({fd, fe}), 32'd0); advance();
    end
    mem_ready = 1;
    sample(); check("defer_flush", 32'(fd), 32'd1); advance();
    clear_inputs();

    // Counter saturation
    do_reset();
    ResultSrcE = 2'b01; RdE = 9; Rs1D = 9;
    for (int i = 0; i < 20; i++) cycle();
    clear_inputs();
    sample(); check("sat4", 32'(scnt4_o), 32'd15); check("sat16", 32'(scnt_o), 32'd20); advance();

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
        Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
        RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
        RdW  = 5'($urandom_range(0, 3));
        ResultSrcE = 2'($urandom_range(0, 3));
        PCSrcE    = ($urandom_range(0, 5) == 0);
        RegWriteM = 1'($urandom_range(0, 1));
        RegWriteW = 1'($urandom_range(0, 1));
        MemAccessM = m_busy ? 1'b1 : ($urandom_range(0, 3) == 0);
        mem_ready = ((n / 200) % 2 == 1) ? ($urandom_range(0, 24) == 0)
                                         : ($urandom_range(0, 2) == 0);
        cycle();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

endmodule
